// File: rtl/spu_mamem_arb.sv
// spu_mamem_arb: owner-based arbiter for the single-ported MA scratch memory.
// Ownership is granted round-robin among ldop fill (0), stop drain (1),
// exp operand read (2) and mulred (3). Only the owner's accesses reach the
// memory port, and a one-cycle DRAIN lets the last read return after the
// owner lets go.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no owner; arbitrate own_req starting at rr_ptr
//  OWN   | own_gnt holds one owner; its accesses are forwarded
//  DRAIN | ownership dropped; one cycle for an in-flight read to return
module spu_mamem_arb #(
    parameter int ADDR_W = 8
) (
    input  logic                rclk,
    input  logic                arst_l,
    input  logic                se,
    input  logic [3:0]          own_req,
    input  logic [3:0]          own_rel,
    input  logic [3:0]          acc_vld,
    input  logic [3:0]          acc_we,
    input  logic [4*ADDR_W-1:0] acc_addr,
    input  logic                kill_op,
    output logic [3:0]          own_gnt,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [3:0]          rd_vld,
    output logic                acc_viol
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr, rr_nxt;
    logic [3:0]  gnt_nxt;
    logic [1:0]  owner;
    logic        in_own;
    logic        own_vld;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;

    // Scan enable is consumed by the scan-inserted flops, not by this logic.
    logic        unused_se;
    assign unused_se = se;

    // Encode the one-hot grant into an owner index for the port muxes.
    always_comb begin
        owner = 2'd0;
        case (own_gnt)
            4'b0010: owner = 2'd1;
            4'b0100: owner = 2'd2;
            4'b1000: owner = 2'd3;
            default: owner = 2'd0;
        endcase
    end

    // Memory port: only the owner, and only while in OWN, may strobe.
    always_comb begin
        in_own   = (state == OWN);
        own_vld  = in_own & acc_vld[owner];
        mem_ren  = own_vld & ~acc_we[owner];
        mem_wen  = own_vld &  acc_we[owner];
        mem_addr = own_vld ? acc_addr[owner*ADDR_W +: ADDR_W] : '0;
    end

    // Round-robin pick: first live request at or after rr_ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && own_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-grant decode.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = own_gnt;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    gnt_nxt   = 4'b0001 << win;
                    rr_nxt    = win + 2'd1;
                end
            end
            OWN: begin
                // A release and a kill in the same cycle collapse into one release.
                if ((|(own_rel & own_gnt)) || kill_op) begin
                    state_nxt = DRAIN;
                    gnt_nxt   = 4'b0000;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state   <= IDLE;
            own_gnt <= 4'b0000;
            rr_ptr  <= 2'd0;
        end else begin
            state   <= state_nxt;
            own_gnt <= gnt_nxt;
            rr_ptr  <= rr_nxt;
        end
    end

    // Read-return and violation pulses, one cycle after the access.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rd_vld   <= 4'b0000;
            acc_viol <= 1'b0;
        end else begin
            rd_vld   <= mem_ren ? (4'b0001 << owner) : 4'b0000;
            acc_viol <= |(acc_vld & ~(in_own ? own_gnt : 4'b0000));
        end
    end

endmodule

// File: tb/tb_spu_mamem_arb.sv
// Directed bench for spu_mamem_arb: grant timing, round-robin order,
// intruder blocking, kill/drain, async reset and foreign release.
module tb_spu_mamem_arb;

    localparam int ADDR_W = 8;

    logic                rclk;
    logic                arst_l;
    logic                se;
    logic [3:0]          own_req;
    logic [3:0]          own_rel;
    logic [3:0]          acc_vld;
    logic [3:0]          acc_we;
    logic [4*ADDR_W-1:0] acc_addr;
    logic                kill_op;
    logic [3:0]          own_gnt;
    logic                mem_ren;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [3:0]          rd_vld;
    logic                acc_viol;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_gnt;

    spu_mamem_arb #(.ADDR_W(ADDR_W)) dut (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .se       (se),
        .own_req  (own_req),
        .own_rel  (own_rel),
        .acc_vld  (acc_vld),
        .acc_we   (acc_we),
        .acc_addr (acc_addr),
        .kill_op  (kill_op),
        .own_gnt  (own_gnt),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .rd_vld   (rd_vld),
        .acc_viol (acc_viol)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; registered outputs are checked there too.
    task automatic tick();
        @(negedge rclk);
    endtask

    initial begin
        arst_l   = 1'b0;
        se       = 1'b0;
        own_req  = 4'b0;
        own_rel  = 4'b0;
        acc_vld  = 4'b0;
        acc_we   = 4'b0;
        acc_addr = '0;
        kill_op  = 1'b0;
        tick();
        chk("rst_gnt",  own_gnt, 4'b0);
        chk("rst_rdv",  rd_vld, 4'b0);
        chk("rst_viol", acc_viol, 1'b0);
        chk("rst_ren",  mem_ren, 1'b0);
        chk("rst_wen",  mem_wen, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        arst_l = 1'b1;
        tick();

        // Single requester 2, read at 0x12.
        own_req = 4'b0100;
        tick();
        chk("t1_gnt", own_gnt, 4'b0100);
        own_req = 4'b0;
        acc_vld = 4'b0100;
        acc_addr[2*ADDR_W +: ADDR_W] = 8'h12;
        #1;
        chk("t1_ren",  mem_ren, 1'b1);
        chk("t1_wen",  mem_wen, 1'b0);
        chk("t1_addr", mem_addr, 8'h12);
        tick();
        chk("t1_rdv",  rd_vld, 4'b0100);
        chk("t1_viol", acc_viol, 1'b0);
        acc_vld = 4'b0;
        #1;
        chk("t1_ren_off",  mem_ren, 1'b0);
        chk("t1_addr_off", mem_addr, 8'h00);
        tick();
        chk("t1_rdv_off", rd_vld, 4'b0);

        // Release from a non-owner is ignored.
        own_rel = 4'b0010;
        tick();
        own_rel = 4'b0;
        chk("t6_gnt", own_gnt, 4'b0100);
        tick();
        chk("t6_gnt2", own_gnt, 4'b0100);

        // Owner 2 reads in the same cycle as kill_op.
        acc_vld = 4'b0100;
        acc_addr[2*ADDR_W +: ADDR_W] = 8'h34;
        kill_op = 1'b1;
        #1;
        chk("t4_ren",  mem_ren, 1'b1);
        chk("t4_addr", mem_addr, 8'h34);
        tick();
        acc_vld = 4'b0;
        kill_op = 1'b0;
        chk("t4_rdv_drain", rd_vld, 4'b0100);
        chk("t4_gnt_drain", own_gnt, 4'b0);
        tick();
        chk("t4_rdv_idle", rd_vld, 4'b0);
        chk("t4_gnt_idle", own_gnt, 4'b0);

        // Owner 3 writes while requester 0 intrudes (rr_ptr is 3 here).
        own_req = 4'b1000;
        tick();
        own_req = 4'b0;
        chk("t3_gnt", own_gnt, 4'b1000);
        acc_vld = 4'b1001;
        acc_we  = 4'b1001;
        acc_addr[3*ADDR_W +: ADDR_W] = 8'h40;
        acc_addr[0*ADDR_W +: ADDR_W] = 8'hAA;
        #1;
        chk("t3_wen_a",  mem_wen, 1'b1);
        chk("t3_ren_a",  mem_ren, 1'b0);
        chk("t3_addr_a", mem_addr, 8'h40);
        tick();
        chk("t3_viol_a", acc_viol, 1'b1);
        acc_vld = 4'b0001;
        acc_addr[0*ADDR_W +: ADDR_W] = 8'hBB;
        #1;
        chk("t3_wen_b",  mem_wen, 1'b0);
        chk("t3_addr_b", mem_addr, 8'h00);
        tick();
        chk("t3_viol_b", acc_viol, 1'b1);
        acc_vld = 4'b1000;
        acc_addr[3*ADDR_W +: ADDR_W] = 8'h41;
        #1;
        chk("t3_wen_c",  mem_wen, 1'b1);
        chk("t3_addr_c", mem_addr, 8'h41);
        tick();
        chk("t3_viol_c", acc_viol, 1'b0);
        acc_vld = 4'b0;
        own_rel = 4'b1000;
        tick();
        own_rel = 4'b0;
        chk("t3_gnt_drain", own_gnt, 4'b0);
        acc_vld = 4'b0001;
        #1;
        chk("t3_wen_drain", mem_wen, 1'b0);
        tick();
        chk("t3_viol_drain", acc_viol, 1'b1);
        acc_vld = 4'b0;
        acc_we  = 4'b0;
        tick();
        chk("t3_viol_clr", acc_viol, 1'b0);

        // Full round robin from reset with all four requesting.
        arst_l = 1'b0;
        tick();
        arst_l  = 1'b1;
        own_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("t2_gnt_k%0d_c%0d", k, c), own_gnt, exp_gnt);
                if (c == 2) own_rel = exp_gnt;
                tick();
                own_rel = 4'b0;
            end
            chk($sformatf("t2_gap1_k%0d", k), own_gnt, 4'b0);
            tick();
            chk($sformatf("t2_gap2_k%0d", k), own_gnt, 4'b0);
            if (k == 4) own_req = 4'b0;
            tick();
        end
        chk("t2_idle", own_gnt, 4'b0);

        // Reset while owner 1 is mid-read (rr_ptr is 1 here).
        own_req = 4'b0010;
        tick();
        own_req = 4'b0;
        chk("t5_gnt", own_gnt, 4'b0010);
        acc_vld = 4'b0110;
        acc_addr[1*ADDR_W +: ADDR_W] = 8'h55;
        #1;
        chk("t5_ren",  mem_ren, 1'b1);
        chk("t5_addr", mem_addr, 8'h55);
        tick();
        chk("t5_rdv",  rd_vld, 4'b0010);
        chk("t5_viol", acc_viol, 1'b1);
        arst_l = 1'b0;
        #1;
        chk("t5_rst_gnt",  own_gnt, 4'b0);
        chk("t5_rst_rdv",  rd_vld, 4'b0);
        chk("t5_rst_viol", acc_viol, 1'b0);
        chk("t5_rst_ren",  mem_ren, 1'b0);
        tick();
        arst_l  = 1'b1;
        acc_vld = 4'b0;
        own_req = 4'b0011;
        tick();
        chk("t5_rr_from0", own_gnt, 4'b0001);
        own_req = 4'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
